data_pack: RTL

Width upsizer that sits directly upstream of the data_hs register slice. It collects RATIO narrow input beats into one wide word, with lane 0 at the LSBs. The word is emitted over a valid/ready handshake. An in_last_i marker flushes a partial word; out_keep_o flags the valid lanes and out_last_o marks the flushed word.

---
 rtl/data_pack.sv | 74 +++++++
 1 files changed

// File: rtl/data_pack.sv
// Width upsizer: packs RATIO narrow beats into one wide word, lane 0 at the LSBs.
// A beat marked last closes a partial word early; keep flags which lanes are real.
module data_pack #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_last_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [RATIO-1:0]     out_keep_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] buffer;
  logic [RATIO-1:0]     keep_acc;

  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     merged_keep;

  // The output slot is free when empty or being drained this cycle.
  assign in_ready_o = ~out_valid_o | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign complete   = accept & ((cnt == LAST_CNT) | in_last_i);

  always_comb begin
    merged_data = buffer;
    merged_data[int'(cnt) * IN_WIDTH +: IN_WIDTH] = in_data_i;
    merged_keep = keep_acc | (RATIO'(1) << cnt);
  end

  // Buffer clears on completion so unfilled lanes of the next word read as 0.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt         <= '0;
      buffer      <= '0;
      keep_acc    <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_keep_o  <= '0;
      out_last_o  <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (complete) begin
        out_valid_o <= 1'b1;
        out_data_o  <= merged_data;
        out_keep_o  <= merged_keep;
        out_last_o  <= in_last_i;
        cnt         <= '0;
        buffer      <= '0;
        keep_acc    <= '0;
      end else if (accept) begin
        cnt      <= cnt + 1'b1;
        buffer   <= merged_data;
        keep_acc <= merged_keep;
      end
    end
  end

endmodule
